// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: controller for the 10-5-3 drowsiness network.
//   Phase 1 assembles serial weight words (MSB first) and writes them to the weight RAM.
//   Phase 2 sweeps weight addresses through a single time-multiplexed MAC.
//     Hidden layer: 5 neurons x 10 inputs. Output layer: 3 neurons x 5 inputs.
// Ports:
//   Clock, Rst (sync, active-high)
//   load inputs : ld_start, In, ld_valid
//   start       : begin inference
//   weight RAM  : wt_we, wt_addr, wt_wdata
//   MAC control : in_idx, layer_sel, mac_clr, mac_en, res_we, res_idx
//   status      : busy, wt_ok, done, err
// Optional: define NN_SEQ_CHECKSUM_EN to add ld_chk, the 16-bit modular sum of the words
//   written during the current load.
module nn_layer_sequencer #(
  parameter int N_IN  = 10,
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int W     = 10,
  parameter int AW    = 7
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          ld_start,
  input  logic          In,
  input  logic          ld_valid,
  input  logic          start,
  output logic          wt_we,
  output logic [AW-1:0] wt_addr,
  output logic [W-1:0]  wt_wdata,
  output logic [3:0]    in_idx,
  output logic          layer_sel,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          res_we,
  output logic [2:0]    res_idx,
  output logic          busy,
  output logic          wt_ok,
  output logic          done,
`ifdef NN_SEQ_CHECKSUM_EN
  output logic [15:0]   ld_chk,
`endif
  output logic          err
);

  localparam int NW = N_IN * N_HID + N_HID * N_OUT;
  localparam int BCW = $clog2(W + 1);
  localparam logic [AW-1:0]  A_LAST     = AW'(NW - 1);
  localparam logic [AW-1:0]  A_HID_LAST = AW'(N_IN * N_HID - 1);
  localparam logic [BCW-1:0] B_LAST     = BCW'(W - 1);
  localparam logic [3:0]     I_HID_LAST = 4'(N_IN - 1);
  localparam logic [3:0]     I_OUT_LAST = 4'(N_HID - 1);

  typedef enum logic [2:0] {IDLE, LOAD, HID, OUT, FLUSH, DONE} state_t;

  state_t state, nxt;

  logic [W-2:0]   sreg;       // bits received so far for the current word
  logic [W-1:0]   shifted;    // word including this cycle's bit
  logic [BCW-1:0] bit_cnt;
  logic [AW-1:0]  word_cnt;
  logic [3:0]     inp_cnt;    // input index of the address being issued
  logic [2:0]     nrn_cnt;    // neuron index of the address being issued
  logic           flush_cnt;
  logic [2:0]     cur_nrn;    // neuron of the term now on mac_en
  logic           cur_last;   // term now on mac_en is the neuron's last

  assign shifted = {sreg, In};

  always_ff @(posedge Clock) begin
    if (Rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = (state != IDLE);
    done = (state == DONE);
    case (state)
      IDLE:    if (ld_start) nxt = LOAD;
               else if (start && wt_ok) nxt = HID;
      LOAD:    if (wt_we && wt_addr == A_LAST) nxt = IDLE;
      HID:     if (wt_addr == A_HID_LAST) nxt = OUT;
      OUT:     if (wt_addr == A_LAST) nxt = FLUSH;
      FLUSH:   if (flush_cnt) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      wt_we     <= 1'b0;
      wt_addr   <= '0;
      wt_wdata  <= '0;
      in_idx    <= '0;
      layer_sel <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      res_we    <= 1'b0;
      res_idx   <= '0;
      wt_ok     <= 1'b0;
      err       <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      inp_cnt   <= '0;
      nrn_cnt   <= '0;
      flush_cnt <= 1'b0;
      cur_nrn   <= '0;
      cur_last  <= 1'b0;
    end else begin
      wt_we   <= 1'b0;
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      res_we  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            word_cnt <= '0;
            bit_cnt  <= '0;
          end else if (start) begin
            if (wt_ok) begin
              wt_addr   <= '0;
              inp_cnt   <= '0;
              nrn_cnt   <= '0;
              flush_cnt <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          // Bits keep flowing during the write cycle; the write uses its own registers.
          if (ld_valid) begin
            sreg <= shifted[W-2:0];
            if (bit_cnt == B_LAST) begin
              bit_cnt  <= '0;
              wt_we    <= 1'b1;
              wt_addr  <= word_cnt;
              wt_wdata <= shifted;
              if (word_cnt != A_LAST) word_cnt <= word_cnt + AW'(1);
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
          if (wt_we && wt_addr == A_LAST) wt_ok <= 1'b1;
        end
        HID, OUT: begin
          // Operand controls trail their address by one cycle to line up with RAM data.
          mac_en    <= 1'b1;
          mac_clr   <= (inp_cnt == '0);
          in_idx    <= inp_cnt;
          layer_sel <= (state == OUT);
          cur_nrn   <= nrn_cnt;
          cur_last  <= (state == HID) ? (inp_cnt == I_HID_LAST) : (inp_cnt == I_OUT_LAST);
          if (state == HID && wt_addr == A_HID_LAST) begin
            wt_addr <= wt_addr + AW'(1);
            inp_cnt <= '0;
            nrn_cnt <= '0;
          end else if (wt_addr != A_LAST) begin
            wt_addr <= wt_addr + AW'(1);
            if ((state == HID) ? (inp_cnt == I_HID_LAST) : (inp_cnt == I_OUT_LAST)) begin
              inp_cnt <= '0;
              nrn_cnt <= nrn_cnt + 3'd1;
            end else begin
              inp_cnt <= inp_cnt + 4'd1;
            end
          end
        end
        FLUSH:   flush_cnt <= 1'b1;
        default: ;
      endcase
      // The result write follows the neuron's final accumulate, so it may land in FLUSH.
      if (mac_en && cur_last) begin
        res_we  <= 1'b1;
        res_idx <= cur_nrn;
      end
    end
  end

`ifdef NN_SEQ_CHECKSUM_EN
  always_ff @(posedge Clock) begin
    if (Rst) begin
      ld_chk <= '0;
    end else if (state == IDLE && ld_start) begin
      ld_chk <= '0;
    end else if (state == LOAD && ld_valid && bit_cnt == B_LAST) begin
      ld_chk <= ld_chk + 16'(shifted);
    end
  end
`endif

endmodule
